// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder composed of two half adders; the two partial carries can
// never both be high, so a plain OR merges them.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// 1-bit half adder cell from the datapath-components library.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one shared full adder cell walks the operands LSB
// first over WIDTH cycles, with a start/busy/done handshake around it.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opb_reg, partial_reg, partial_next;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  full_adder u_fa (
    .a    (opa_reg[0]),
    .b    (opb_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New result bit enters at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign partial_next = fa_s;
    end else begin : g_wn
      assign partial_next = {fa_s, partial_reg[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  assign busy     = (state_reg == ST_SHIFT);
  assign done     = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_reg     <= '0;
      opb_reg     <= '0;
      partial_reg <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      sum         <= '0;
      cout        <= 1'b0;
    end else if (accept) begin
      opa_reg     <= a;
      opb_reg     <= b;
      carry_reg   <= cin;
      partial_reg <= '0;
      cnt_reg     <= '0;
    end else if (state_reg == ST_SHIFT) begin
      opa_reg     <= opa_reg >> 1;
      opb_reg     <= opb_reg >> 1;
      carry_reg   <= fa_c;
      partial_reg <= partial_next;
      cnt_reg     <= cnt_reg + CNT_W'(1);
      // Results only move on the completing edge and hold otherwise.
      if (last_bit) begin
        sum  <= partial_next;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1
// builds), checked against an integer-sum reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, sum1, cout1;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operand inputs.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    cin   = tc;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Called in the first busy cycle; returns in the done cycle.
  task automatic finish_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tc, input bit noise);
    logic [W:0] total;
    total = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    for (int i = 0; i < W; i++) begin
      check("busy", busy, 1);
      check("done_in_shift", done, 0);
      check("sum_hold", sum, held_sum);
      check("cout_hold", cout, held_cout);
      if (noise) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("sum", sum, total[W-1:0]);
    check("cout", cout, total[W]);
    held_sum  = total[W-1:0];
    held_cout = total[W];
    $display("add a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", ta, tb_, tc, sum, cout);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_sum", sum, held_sum);
    check("idle_cout", cout, held_cout);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [1:0]   t1;

    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_w1_busy", busy1, 0);
    check("rst_w1_sum", sum1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(8'h5A, 8'h33, 1'b0);
    finish_op(8'h5A, 8'h33, 1'b0, 1'b0);
    check("tp_5a33_sum", sum, 8'h8D);
    idle_check();

    launch(8'hFF, 8'h01, 1'b0);
    finish_op(8'hFF, 8'h01, 1'b0, 1'b0);
    check("tp_ff01_cout", cout, 1);
    idle_check();
    launch(8'hFF, 8'h00, 1'b1);
    finish_op(8'hFF, 8'h00, 1'b1, 1'b0);
    idle_check();

    // Start and operand noise during SHIFT must be ignored.
    launch(8'h12, 8'h34, 1'b1);
    finish_op(8'h12, 8'h34, 1'b1, 1'b1);
    idle_check();
    idle_check();

    // Back-to-back: start held in the done cycle.
    launch(8'hAB, 8'hCD, 1'b0);
    finish_op(8'hAB, 8'hCD, 1'b0, 1'b0);
    launch(8'h01, 8'h01, 1'b0);
    finish_op(8'h01, 8'h01, 1'b0, 1'b0);
    check("tp_b2b_sum", sum, 8'h02);
    idle_check();

    // Asynchronous reset in the middle of SHIFT.
    launch(8'h77, 8'h88, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    held_sum  = '0;
    held_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check();
    launch(8'h10, 8'h20, 1'b0);
    finish_op(8'h10, 8'h20, 1'b0, 1'b0);
    check("tp_post_rst_sum", sum, 8'h30);
    idle_check();

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      finish_op(ra, rb, rc, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    // WIDTH=1 build: every operand combination.
    for (int v = 0; v < 8; v++) begin
      start1 = 1'b1;
      a1     = v[0];
      b1     = v[1];
      cin1   = v[2];
      t1     = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", busy1, 1);
      check("w1_done_early", done1, 0);
      @(negedge clk);
      check("w1_done", done1, 1);
      check("w1_sum", sum1, t1[0]);
      check("w1_cout", cout1, t1[1]);
      $display("w1 add a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", v[0], v[1], v[2], sum1, cout1);
      @(negedge clk);
      check("w1_idle_done", done1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
